// File: rtl/flex_counter_multi.sv
// flex_counter_multi
//   NUM_CHANNELS independent W-bit counters. Each channel has its own
//   rollover value, up/down direction, synchronous clear and load, a held
//   terminal flag and a one-cycle wrap pulse.
//
//   Compile-time option FLEX_CASCADE_EN: when defined, channel i (i >= 1)
//   only steps when its own enable is high and channel i-1 wraps in the
//   same cycle, forming a multi-digit counter. When undefined, the
//   channels are fully independent.
//
// Ports (channel i occupies bits [i] or [i*W +: W]):
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   clear         in   N    synchronous clear (highest priority)
//   count_enable  in   N    step enable
//   count_down    in   N    direction: 0 = up, 1 = down
//   load          in   N    synchronous load of load_val
//   load_val      in   N*W  load values
//   rollover_val  in   N*W  rollover values (0 disables stepping)
//   count_out     out  N*W  registered counts
//   rollover_flag out  N    registered: count equals terminal value
//   wrap_pulse    out  N    registered one-cycle pulse after a wrap
module flex_counter_multi #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CHANNELS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CHANNELS-1:0]              clear,
    input  logic [NUM_CHANNELS-1:0]              count_enable,
    input  logic [NUM_CHANNELS-1:0]              count_down,
    input  logic [NUM_CHANNELS-1:0]              load,
    input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CHANNELS-1:0]              rollover_flag,
    output logic [NUM_CHANNELS-1:0]              wrap_pulse
);

    localparam int W = NUM_CNT_BITS;
    localparam int N = NUM_CHANNELS;

    logic [N*W-1:0] count_q, count_d;
    logic [N-1:0]   flag_q, flag_d;
    logic [N-1:0]   wrap_q, wrap_now;

    always_comb begin : next_state
        logic [W-1:0] cnt;
        logic [W-1:0] rv;
        logic [W-1:0] nxt;
        logic [W-1:0] term;
        logic         en;
        logic         wrap;
`ifdef FLEX_CASCADE_EN
        logic         carry;
        // Channel 0 sees a permanent carry so it uses its own enable only.
        carry = 1'b1;
`endif
        count_d  = count_q;
        flag_d   = flag_q;
        wrap_now = '0;
        cnt      = '0;
        rv       = '0;
        nxt      = '0;
        term     = '0;
        en       = 1'b0;
        wrap     = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt  = count_q[i*W +: W];
            rv   = rollover_val[i*W +: W];
            wrap = 1'b0;
`ifdef FLEX_CASCADE_EN
            en = count_enable[i] & carry;
`else
            en = count_enable[i];
`endif
            if (clear[i]) begin
                nxt = '0;
            end else if (load[i]) begin
                nxt = load_val[i*W +: W];
            end else if (en && (rv != '0)) begin
                if (!count_down[i]) begin
                    if (cnt >= rv) begin
                        nxt  = W'(1);
                        wrap = 1'b1;
                    end else begin
                        nxt = cnt + W'(1);
                    end
                end else begin
                    if (cnt == W'(1)) begin
                        nxt  = rv;
                        wrap = 1'b1;
                    end else if ((cnt == '0) || (cnt > rv)) begin
                        // Out-of-range or cleared count re-enters at the top; not a wrap.
                        nxt = rv;
                    end else begin
                        nxt = cnt - W'(1);
                    end
                end
            end else begin
                nxt = cnt;
            end
            // Flag looks at the next count against the direction sampled now,
            // so it stays valid (held) while the channel is idle.
            term = count_down[i] ? W'(1) : rv;
            count_d[i*W +: W] = nxt;
            flag_d[i]         = (rv != '0) && (nxt == term);
            wrap_now[i]       = wrap;
`ifdef FLEX_CASCADE_EN
            carry = wrap;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            flag_q  <= '0;
            wrap_q  <= '0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
            wrap_q  <= wrap_now;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = flag_q;
    assign wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_flex_counter_multi.sv
module tb_flex_counter_multi;

    localparam int W = 4;
    localparam int N = 2;
`ifdef FLEX_CASCADE_EN
    localparam bit CASCADE = 1'b1;
`else
    localparam bit CASCADE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   clear = '0;
    logic [N-1:0]   count_enable = '0;
    logic [N-1:0]   count_down = '0;
    logic [N-1:0]   load = '0;
    logic [N*W-1:0] load_val = '0;
    logic [N*W-1:0] rollover_val = '0;
    logic [N*W-1:0] count_out;
    logic [N-1:0]   rollover_flag;
    logic [N-1:0]   wrap_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers per channel.
    int unsigned m_cnt [N];
    bit          m_flag[N];
    bit          m_wrap[N];
    int unsigned n_cnt [N];
    bit          n_flag[N];
    bit          n_wrap[N];

    flex_counter_multi #(.NUM_CNT_BITS(W), .NUM_CHANNELS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .count_enable (count_enable),
        .count_down   (count_down),
        .load         (load),
        .load_val     (load_val),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .wrap_pulse   (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_flag[i] = 0; m_wrap[i] = 0;
        end
    endtask

    // Behaviour from the rules: decide what the channel does this cycle,
    // then derive the flag from where it lands.
    task automatic model_predict();
        bit carry;
        carry = 1'b1;
        for (int i = 0; i < N; i++) begin
            int unsigned rv, c, n;
            bit stepping, wrapped, down;
            rv   = rollover_val[i*W +: W];
            c    = m_cnt[i];
            down = count_down[i];
            stepping = count_enable[i] && (rv != 0) && (!CASCADE || carry);
            wrapped  = 0;
            n        = c;
            if (clear[i])               n = 0;
            else if (load[i])           n = load_val[i*W +: W];
            else if (stepping && !down) begin
                wrapped = (c >= rv);
                n = wrapped ? 1 : c + 1;
            end else if (stepping && down) begin
                wrapped = (c == 1);
                n = (c == 1 || c == 0 || c > rv) ? rv : c - 1;
            end
            n_cnt[i]  = n;
            n_wrap[i] = wrapped;
            n_flag[i] = (rv != 0) && (n == (down ? 1 : rv));
            carry     = wrapped;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [N*W-1:0] ec;
        logic [N-1:0]   ef, ew;
        for (int i = 0; i < N; i++) begin
            ec[i*W +: W] = W'(m_cnt[i]);
            ef[i] = m_flag[i];
            ew[i] = m_wrap[i];
        end
        chk({tag, ".count"}, 32'(count_out), 32'(ec));
        chk({tag, ".flag"},  32'(rollover_flag), 32'(ef));
        chk({tag, ".wrap"},  32'(wrap_pulse), 32'(ew));
    endtask

    // One clock: predict from current inputs, let the edge pass, compare #1 later.
    task automatic cycle(input string tag);
        model_predict();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = n_cnt[i]; m_flag[i] = n_flag[i]; m_wrap[i] = n_wrap[i];
        end
        chk_model(tag);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        model_reset();
        chk_model("reset_pulse");
        rst = 1'b0;
    endtask

    int up_c [7]  = '{1, 2, 3, 4, 5, 1, 2};
    int up_f [7]  = '{0, 0, 0, 0, 1, 0, 0};
    int up_w [7]  = '{0, 0, 0, 0, 0, 1, 0};
    int dn_c [5]  = '{3, 2, 1, 3, 2};
    int dn_f [5]  = '{0, 0, 1, 0, 0};
    int dn_w [5]  = '{0, 0, 0, 1, 0};
    int cs0  [7]  = '{1, 2, 3, 1, 2, 3, 1};
    int cs1c [7]  = '{0, 0, 0, 1, 1, 1, 2};
    int cs1i [7]  = '{1, 2, 1, 2, 1, 2, 1};

    initial begin
        model_reset();
        #3;
        chk_model("reset_initial");
        chk("reset_count_zero", 32'(count_out), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Up wrap on ch0, rv=5.
        rollover_val[0 +: W] = 4'd5;
        count_enable[0] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cycle("up_wrap");
            chk("up_cnt",  32'(count_out[0 +: W]), 32'(up_c[k]));
            chk("up_flag", 32'(rollover_flag[0]), 32'(up_f[k]));
            chk("up_wrap", 32'(wrap_pulse[0]), 32'(up_w[k]));
        end
        for (int k = 0; k < 3; k++) cycle("up_to5");
        count_enable[0] = 1'b0;
        cycle("idle1");
        cycle("idle2");
        chk("flag_held_idle", 32'(rollover_flag[0]), 32'h1);
        chk("count_held_idle", 32'(count_out[0 +: W]), 32'd5);

        // Reset asserted between edges while counting.
        count_enable[0] = 1'b1;
        cycle("pre_reset");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk_model("mid_reset");
        chk("mid_reset_count", 32'(count_out), 32'h0);
        #1;
        rst = 1'b0;
        cycle("post_reset");
        chk("post_reset_first", 32'(count_out[0 +: W]), 32'd1);
        count_enable[0] = 1'b0;

        // Down wrap on ch1, rv=3.
        rollover_val[W +: W] = 4'd3;
        count_down[1] = 1'b1;
        count_enable[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle("down_wrap");
            if (!CASCADE) begin
                chk("dn_cnt",  32'(count_out[W +: W]), 32'(dn_c[k]));
                chk("dn_flag", 32'(rollover_flag[1]), 32'(dn_f[k]));
                chk("dn_wrap", 32'(wrap_pulse[1]), 32'(dn_w[k]));
            end
        end
        count_enable[1] = 1'b0;
        count_down[1] = 1'b0;

        // Priority and load on ch0.
        clear[0] = 1'b1; load[0] = 1'b1; count_enable[0] = 1'b1;
        load_val[0 +: W] = 4'd9;
        cycle("prio");
        chk("prio_clear", 32'(count_out[0 +: W]), 32'd0);
        clear[0] = 1'b0; count_enable[0] = 1'b0;
        cycle("load9");
        chk("load_over_rv", 32'(count_out[0 +: W]), 32'd9);
        load[0] = 1'b0; count_enable[0] = 1'b1;
        cycle("step_from9");
        chk("wrap_from9_cnt", 32'(count_out[0 +: W]), 32'd1);
        chk("wrap_from9_pulse", 32'(wrap_pulse[0]), 32'h1);
        load[0] = 1'b1; count_enable[0] = 1'b0; load_val[0 +: W] = 4'd5;
        cycle("load5");
        chk("load5_flag", 32'(rollover_flag[0]), 32'h1);
        load[0] = 1'b0;

        // Disabled channel (rv=0) then re-enabled with rv=2.
        clear[0] = 1'b1;
        cycle("clr");
        clear[0] = 1'b0;
        rollover_val[0 +: W] = 4'd0;
        count_enable[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle("rv0");
            chk("rv0_state", 32'({count_out[0 +: W], rollover_flag[0], wrap_pulse[0]}), 32'h0);
        end
        rollover_val[0 +: W] = 4'd2;
        cycle("rv2_a"); chk("rv2_1", 32'(count_out[0 +: W]), 32'd1);
        cycle("rv2_b"); chk("rv2_2", 32'(count_out[0 +: W]), 32'd2);
        cycle("rv2_c"); chk("rv2_wrap", 32'({count_out[0 +: W], wrap_pulse[0]}), 32'h3);

        // Cascade scenario (expectations depend on build option).
        pulse_reset();
        rollover_val = '0;
        rollover_val[0 +: W] = 4'd3;
        rollover_val[W +: W] = 4'd2;
        count_down = '0;
        count_enable = '1;
        for (int k = 0; k < 7; k++) begin
            cycle("cascade");
            chk("casc_ch0", 32'(count_out[0 +: W]), 32'(cs0[k]));
            chk("casc_ch1", 32'(count_out[W +: W]), 32'(CASCADE ? cs1c[k] : cs1i[k]));
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                clear[i]        = ($urandom_range(0, 15) == 0);
                load[i]         = ($urandom_range(0, 11) == 0);
                count_enable[i] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0) count_down[i] = ~count_down[i];
                load_val[i*W +: W] = W'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0)
                    rollover_val[i*W +: W] = W'($urandom_range(0, 3) == 0 ?
                                                $urandom_range(0, 15) : $urandom_range(0, 5));
            end
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flex_counter_multi.md
# flex_counter_multi

Parametrised multi-channel successor to the single-channel flex counter. It provides NUM_CHANNELS independent counters with per-channel rollover value, up/down direction, synchronous load and clear, a held terminal flag and a one-cycle wrap pulse. An optional compile-time cascade mode chains the channels into a multi-digit counter. It is used by the timing/serial blocks that need several related counts (bit, byte, frame) from one instance.

## Interface
- NUM_CNT_BITS, 4: counter width W per channel (≥2)
- NUM_CHANNELS, 2: number of channels N (≥1)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  N  per-channel synchronous clear
- count_enable  in  N  per-channel step enable
- count_down  in  N  per-channel direction: 0 = up, 1 = down
- load  in  N  per-channel synchronous load
- load_val  in  N*W  load values; channel i at bits [i*W +: W]
- rollover_val  in  N*W  rollover values; same packing
- count_out  out  N*W  registered counts; same packing
- rollover_flag  out  N  registered; high while channel count equals its terminal value
- wrap_pulse  out  N  registered one-cycle pulse on the first cycle after a wrap

## Operation
- Per-channel update priority: clear > load > step > hold.
- clear: count ← 0.
- load: count ← load_val, loaded as-is even if it exceeds rollover_val.
- rollover_val = 0 disables the channel's stepping. Count holds, and wrap_pulse stays 0. Clear and load still act.
- Up step (count_down=0):
  - if count ≥ rollover_val, count ← 1 (wrap);
  - else count ← count+1.
  - From reset, 0 → 1 is not a wrap.
- Down step (count_down=1):
  - if count == 1, count ← rollover_val (wrap);
  - if count == 0 or count > rollover_val, count ← rollover_val (not a wrap);
  - else count ← count−1.
- Terminal value: rollover_val when counting up, 1 when counting down. Never terminal when rollover_val = 0.
- rollover_flag: registered with the count, equal to (next count == terminal value under the next-cycle direction input sampled now).
  - The flag is held while the channel is idle, unlike the older counter, which dropped it when enable fell.
  - After clear it is 0. After load it is evaluated on load_val.
- wrap_now[i]: combinational, high when channel i performs a wrap step this cycle. wrap_pulse[i] is wrap_now[i] registered.
- All arithmetic is W-bit unsigned. Overflow is never relied on.

## Timing
- Reset: count_out = 0, rollover_flag = 0, wrap_pulse = 0, forced asynchronously while rst is high. The first update happens on the first rising edge after rst falls.
- Reset asserted mid-count clears all channels immediately. There is no partial state.
- Latency: one cycle from sampled clear/load/enable to count_out, rollover_flag and wrap_pulse.
- Inputs, including rollover_val and count_down, may change on any cycle and take effect on the next edge.
  - Lowering rollover_val below the current count makes the next up step wrap to 1 and the next down step go to rollover_val.
- No handshake. A step occurs on every cycle where count_enable is high.

## Configuration
- FLEX_CASCADE_EN defined:
  - For i ≥ 1, the effective enable of channel i is count_enable[i] & wrap_now[i−1], a combinational ripple from channel 0 upward. Channel 0 uses count_enable[0] directly.
  - Clear and load are not cascaded.
- FLEX_CASCADE_EN undefined: all channels are fully independent and wrap_now is not routed between channels.

## Test plan
- Reset mid-operation: ch0 counting with rv=5, raise rst between edges → all outputs 0 before the next edge. Release rst → first step gives count 1.
- Up wrap: ch0 rv=5, enable held 7 cycles from reset → count_out 1,2,3,4,5,1,2. rollover_flag is high only with 5. wrap_pulse is high only with the second 1. Drop enable at 5 → flag stays high.
- Down wrap: ch1 rv=3, count_down=1, enable 5 cycles from reset → 3,2,1,3,2. Flag high with 1. wrap_pulse high with the second 3.
- Priority and load: clear, load(9) and enable all high in the same cycle → 0. Then load 9 with rv=5 up → 9, next step → 1 with wrap_pulse. Load 5 → flag high next cycle.
- Disabled channel: rv=0, enable 4 cycles → count stays 0, flag 0, wrap_pulse 0. Change rv to 2 → steps 1,2,1.
- Cascade (FLEX_CASCADE_EN): rv0=3, rv1=2, both enables held → ch0 1,2,3,1,2,3,1 while ch1 goes 0→1 on ch0's first wrap and 1→2 on the second. Without the macro, ch1 steps every cycle.
